// File: rtl/qspi_rx_line_fill_if.sv
// Handshake and data bundle between the QSPI line-fill receiver and its controller/consumer.
// master drives control, IO nibbles and word_ready; slave is the receiver.
interface qspi_rx_line_fill_if #(
  parameter int LINE_WORDS = 8
);
  localparam int IDXW = $clog2(LINE_WORDS);

  logic            start;
  logic            abort;
  logic            hdr_done;
  logic [3:0]      io_in;
  logic            sclk_en;
  logic [31:0]     word_data;
  logic [IDXW-1:0] word_idx;
  logic            word_valid;
  logic            word_ready;
  logic            busy;
  logic            line_done;

  modport master (
    output start, abort, hdr_done, io_in, word_ready,
    input  sclk_en, word_data, word_idx, word_valid, busy, line_done
  );

  modport slave (
    input  start, abort, hdr_done, io_in, word_ready,
    output sclk_en, word_data, word_idx, word_valid, busy, line_done
  );
endinterface

// File: rtl/qspi_rx_line_fill.sv
// Packs QSPI data nibbles into 32-bit words for one cache line, queues them in a small FIFO
// and hands them out valid/ready tagged with word index; SPI clock is gated while the FIFO is full.
module qspi_rx_line_fill #(
  parameter int LINE_WORDS = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  qspi_rx_line_fill_if.slave bus
);
  localparam int IDXW = $clog2(LINE_WORDS);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_HDR, CAPTURE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [2:0]      nib_cnt;
  logic [IDXW-1:0] word_cnt;
  logic [31:0]     acc, acc_nxt;
  logic [31:0]     mem_dat [FIFO_DEPTH];
  logic [IDXW-1:0] mem_idx [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;

  logic fifo_full, fifo_empty, sample, push, pop, last_word;

  assign fifo_full  = (count == CNTW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign sample     = (state == CAPTURE) && !fifo_full && !bus.abort;
  assign push       = sample && (nib_cnt == 3'd7);
  assign pop        = bus.word_valid && bus.word_ready;
  assign last_word  = (word_cnt == IDXW'(LINE_WORDS - 1));

  // Byte n holds nibbles 2n (high half) and 2n+1 (low half).
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{nib_cnt[2:1], ~nib_cnt[0], 2'b00} +: 4] = bus.io_in;
  end

  assign bus.sclk_en    = sample;
  assign bus.word_valid = !fifo_empty && !bus.abort;
  assign bus.word_data  = mem_dat[rd_ptr];
  assign bus.word_idx   = mem_idx[rd_ptr];
  assign bus.busy       = (state != IDLE);
  assign bus.line_done  = pop && (mem_idx[rd_ptr] == IDXW'(LINE_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (bus.start)           state_nxt = WAIT_HDR;
        WAIT_HDR: if (bus.hdr_done)        state_nxt = CAPTURE;
        CAPTURE:  if (push && last_word)   state_nxt = DRAIN;
        DRAIN:    if (bus.line_done || fifo_empty) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_cnt  <= '0;
      word_cnt <= '0;
      acc      <= '0;
    end else if (bus.abort || (state == IDLE && bus.start)) begin
      nib_cnt  <= '0;
      word_cnt <= '0;
    end else if (sample) begin
      nib_cnt <= nib_cnt + 3'd1;
      acc     <= acc_nxt;
      if (push) word_cnt <= word_cnt + 1'b1;
    end
  end

  // Push and pop never coincide while full because capture is gated then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dat[i] <= '0;
        mem_idx[i] <= '0;
      end
    end else if (bus.abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_dat[wr_ptr] <= acc_nxt;
        mem_idx[wr_ptr] <= word_cnt;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_qspi_rx_line_fill.sv
// Randomized scoreboard bench for qspi_rx_line_fill: stimulus queues expected words,
// an independent monitor checks every accepted word and line_done pulse.
module tb_qspi_rx_line_fill;
  localparam int LW   = 8;
  localparam int FD   = 4;
  localparam int IDXW = $clog2(LW);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qspi_rx_line_fill_if #(.LINE_WORDS(LW)) bus ();

  qspi_rx_line_fill #(.LINE_WORDS(LW), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0]     dat;
    logic [IDXW-1:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] stream[$];
  int total = 0, bad = 0;
  int ptr = 0, en_cnt = 0, ready_mode = 0;
  int pops_fill = 0, lines_seen = 0, lines_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference packing: nibble k lands in byte k/2, high half for even k.
  function automatic logic [31:0] pack_word(input int base);
    logic [31:0] w = '0;
    for (int k = 0; k < 8; k++)
      w |= 32'(stream[base + k]) << (8 * (k / 2) + 4 * (1 - k % 2));
    return w;
  endfunction

  task automatic tick(input logic s, input logic a, input logic h);
    @(negedge clk);
    bus.start    = s;
    bus.abort    = a;
    bus.hdr_done = h;
    bus.io_in    = (ptr < stream.size()) ? stream[ptr] : 4'(ptr);
    case (ready_mode)
      0:       bus.word_ready = 1'b1;
      1:       bus.word_ready = 1'b0;
      2:       bus.word_ready = 1'($urandom_range(0, 1));
      3:       bus.word_ready = (pops_fill < 6);
      default: bus.word_ready = (en_cnt == 31);
    endcase
    #1;
    if (bus.sclk_en) begin
      ptr++;
      en_cnt++;
    end
  endtask

  // pat 0: nibbles 0..7, pat 1: every nibble equals word number, else random.
  task automatic load_fill(input int pat);
    stream.delete();
    ptr = 0; en_cnt = 0; pops_fill = 0;
    for (int w = 0; w < LW; w++)
      for (int k = 0; k < 8; k++)
        stream.push_back(pat == 0 ? 4'(k) : pat == 1 ? 4'(w) : 4'($urandom_range(0, 15)));
    for (int w = 0; w < LW; w++)
      exp_q.push_back('{dat: pack_word(w * 8), idx: IDXW'(w)});
  endtask

  task automatic start_fill();
    tick(1'b1, 1'b0, 1'b0);
    repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("sclk_en_in_hdr_cycle", 32'(bus.sclk_en), 0);
  endtask

  task automatic run_to_idle(input int budget, input string name);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    check(name, 32'(bus.busy), 0);
  endtask

  logic hs, exp_last;
  exp_t e;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      hs       = bus.word_valid && bus.word_ready;
      exp_last = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(hs), 0);
        end else begin
          e = exp_q.pop_front();
          check("word_data", bus.word_data, e.dat);
          check("word_idx", 32'(bus.word_idx), 32'(e.idx));
          exp_last = (e.idx == IDXW'(LW - 1));
        end
        pops_fill++;
      end
      if (bus.line_done || exp_last) check("line_done", 32'(bus.line_done), 32'(exp_last));
      if (bus.line_done) lines_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.hdr_done = 1'b0;
    bus.io_in = 4'h0; bus.word_ready = 1'b0;
    #1;
    check("rst_busy",       32'(bus.busy), 0);
    check("rst_word_valid", 32'(bus.word_valid), 0);
    check("rst_sclk_en",    32'(bus.sclk_en), 0);
    check("rst_line_done",  32'(bus.line_done), 0);
    check("rst_word_data",  bus.word_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single line, consumer always ready.
    ready_mode = 0;
    load_fill(0); lines_exp++;
    start_fill();
    run_to_idle(300, "t1_idle");
    check("t1_sclk_cycles", en_cnt, 64);
    check("t1_lines", lines_seen, lines_exp);

    // Full backpressure: capture stops at four queued words.
    ready_mode = 1;
    load_fill(1); lines_exp++;
    start_fill();
    repeat (60) tick(1'b0, 1'b0, 1'b0);
    check("bp_stall_nibbles", en_cnt, 32);
    check("bp_sclk_en_low",   32'(bus.sclk_en), 0);
    check("bp_word_valid",    32'(bus.word_valid), 1);
    ready_mode = 0;
    run_to_idle(300, "bp_idle");
    check("bp_sclk_cycles", en_cnt, 64);
    check("bp_lines", lines_seen, lines_exp);

    // One push and pop together at occupancy 3, then stall again.
    ready_mode = 4;
    load_fill(2); lines_exp++;
    start_fill();
    repeat (60) tick(1'b0, 1'b0, 1'b0);
    check("pp_stall_nibbles", en_cnt, 40);
    check("pp_sclk_en_low",   32'(bus.sclk_en), 0);
    ready_mode = 0;
    run_to_idle(300, "pp_idle");
    check("pp_sclk_cycles", en_cnt, 64);

    // Abort after 13 nibbles.
    ready_mode = 0;
    load_fill(2);
    start_fill();
    n = 0;
    while (en_cnt < 13 && n < 100) begin tick(1'b0, 1'b0, 1'b0); n++; end
    check("ab_nibbles_before", en_cnt, 13);
    tick(1'b0, 1'b1, 1'b0);
    check("ab_sclk_en_during",    32'(bus.sclk_en), 0);
    check("ab_word_valid_during", 32'(bus.word_valid), 0);
    exp_q.delete();
    tick(1'b0, 1'b0, 1'b0);
    check("ab_busy",       32'(bus.busy), 0);
    check("ab_word_valid", 32'(bus.word_valid), 0);
    check("ab_no_line_done", lines_seen, lines_exp);
    load_fill(0); lines_exp++;
    start_fill();
    run_to_idle(300, "ab_refill_idle");
    check("ab_refill_lines", lines_seen, lines_exp);

    // Ignored inputs.
    tick(1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("ign_hdr_idle_busy", 32'(bus.busy), 0);
    check("ign_hdr_idle_sclk", 32'(bus.sclk_en), 0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("ign_abort_start_busy", 32'(bus.busy), 0);
    load_fill(2); lines_exp++;
    start_fill();
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    run_to_idle(300, "ign_start_busy_idle");
    check("ign_start_busy_nibbles", en_cnt, 64);
    check("ign_lines", lines_seen, lines_exp);

    // Asynchronous reset in DRAIN with two words queued.
    ready_mode = 3;
    load_fill(2);
    start_fill();
    n = 0;
    while (en_cnt < 64 && n < 300) begin tick(1'b0, 1'b0, 1'b0); n++; end
    tick(1'b0, 1'b0, 1'b0);
    check("rd_busy_before",  32'(bus.busy), 1);
    check("rd_valid_before", 32'(bus.word_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("rd_async_valid", 32'(bus.word_valid), 0);
    check("rd_async_busy",  32'(bus.busy), 0);
    check("rd_async_sclk",  32'(bus.sclk_en), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    check("rd_after_valid", 32'(bus.word_valid), 0);
    check("rd_after_busy",  32'(bus.busy), 0);

    // Random data with random consumer stalls.
    for (int r = 0; r < 4; r++) begin
      ready_mode = 2;
      load_fill(2); lines_exp++;
      start_fill();
      run_to_idle(2000, "rnd_idle");
      check("rnd_sclk_cycles", en_cnt, 64);
    end

    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("final_lines", lines_seen, lines_exp);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qspi_rx_line_fill.md
Name: qspi_rx_line_fill

Overview:
- Downstream stage of the QSPI command/address shifter.
- Once the header phase reports done, it samples the 4-bit IO bus one nibble per enabled cycle and packs the nibbles into 32-bit words.
- Buffers the words in a small FIFO and hands them to the cache line-fill logic over a valid/ready handshake, tagged with their word index.
- Stops after one cache line and gates the SPI clock when the consumer backs up.

Parameters:
- LINE_WORDS, 8, words per cache line; power of two, at least 2.
- FIFO_DEPTH, 4, output word FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a line fill; ignored while busy.
- abort  in  1  level; cancels the fill and flushes the FIFO.
- hdr_done  in  1  header phase done (command, address and dummy cycles complete).
- io_in  in  4  QSPI data lines.
- sclk_en  out  1  SPI clock enable; io_in is sampled only on cycles where this is 1.
- word_data  out  32  assembled word.
- word_idx  out  $clog2(LINE_WORDS)  word index within the line.
- word_valid  out  1  FIFO head valid.
- word_ready  in  1  consumer accepts the head.
- busy  out  1  fill in progress.
- line_done  out  1  one-cycle pulse when the last word of the line is accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; all counters 0.
- States:
  - IDLE: start=1 -> WAIT_HDR; clear nibble and word counters.
  - WAIT_HDR: hdr_done=1 -> CAPTURE on the next cycle. The nibble present in the hdr_done cycle is not sampled.
  - CAPTURE:
    - sclk_en = !fifo_full.
    - Each cycle with sclk_en=1 samples io_in into a shift register and increments the nibble counter (0..7).
    - On the 8th nibble the packed word and word counter are written into the FIFO in the same clock edge; the nibble counter wraps to 0 and the word counter increments.
    - After word LINE_WORDS-1 is written -> DRAIN.
  - DRAIN: sclk_en=0. When the FIFO is empty and the last handshake has completed -> IDLE.
- busy = (state != IDLE).
- Packing is little-endian by byte, high nibble first within each byte:
  - nibble0 -> [7:4], nibble1 -> [3:0];
  - nibble2 -> [15:12], nibble3 -> [11:8];
  - and so on up to nibble7 -> [27:24].
- FIFO:
  - Registered storage; word_valid=1 from the cycle after the write.
  - A pop happens when word_valid && word_ready.
  - Simultaneous push and pop while full is impossible, because sclk_en=0 when full.
  - Simultaneous push and pop at any other occupancy keeps the count unchanged.
- word_idx is the FIFO-carried word counter: 0..LINE_WORDS-1, with no wrap inside a line.
- line_done pulses in the cycle the word with word_idx=LINE_WORDS-1 is popped. The state returns to IDLE in that same edge.
- Backpressure:
  - sclk_en drops combinationally in any cycle the FIFO is full; no nibble is lost or duplicated.
  - Capture resumes on the cycle after a pop frees an entry.
- abort=1 (any state):
  - Next state is IDLE; FIFO flushed; counters cleared; sclk_en=0; word_valid=0.
  - line_done is not asserted.
  - abort overrides start in the same cycle.
- hdr_done outside WAIT_HDR is ignored.
- start in DRAIN, or in the same cycle as line_done, is ignored.
- Asynchronous rst mid-fill: all state is cleared immediately; no further outputs until a new start.

Test Plan:
- Single line, word_ready=1:
  - start, hdr_done, then nibbles 0,1,2,3,4,5,6,7 repeated.
  - Each word = 0x67452301, word_idx 0..7 in order.
  - sclk_en high for exactly 64 cycles.
  - line_done pulses once; busy falls.
- Backpressure:
  - word_ready=0 throughout.
  - After 4 words (32 nibbles) sclk_en goes and stays 0.
  - Release word_ready: capture resumes, all 8 words arrive in order with no gaps or repeats.
  - Distinct data per word, e.g. word k = 0x0000000k*0x11111111 pattern.
- Abort mid-word: abort after 13 nibbles -> busy=0, word_valid=0, no line_done. A following fill yields word_idx starting at 0.
- Ignored inputs:
  - start while busy has no effect.
  - hdr_done while IDLE does not start capture.
  - abort and start in the same cycle -> IDLE.
- Reset mid-DRAIN with 2 words queued: rst asserted -> word_valid, busy and sclk_en all 0 immediately, without waiting for a clock edge.
- Simultaneous push and pop at occupancy 3 keeps the count at 3; word order is preserved.
